// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared widths, state encoding and mode/dir constants for the PRESENT block sequencer
package present_pkg;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 80;
    localparam int CNT_W   = 10;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;
    localparam logic DIR_ENC  = 1'b0;
    localparam logic DIR_DEC  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/present_block_ctrl_if.sv
// rtl/present_block_ctrl_if.sv - block streams and cipher-core load/done bundle
interface present_block_ctrl_if;
    import present_pkg::*;

    logic               s_valid;
    logic               s_ready;
    logic [BLOCK_W-1:0] s_data;
    logic               m_valid;
    logic               m_ready;
    logic [BLOCK_W-1:0] m_data;
    logic [BLOCK_W-1:0] core_idat;
    logic [KEY_W-1:0]   core_key;
    logic               core_load;
    logic               core_control;
    logic [BLOCK_W-1:0] core_odat;
    logic               core_done;

    modport master (
        input  s_valid, s_data, m_ready, core_odat, core_done,
        output s_ready, m_valid, m_data, core_idat, core_key, core_load, core_control
    );

    modport slave (
        output s_valid, s_data, m_ready, core_odat, core_done,
        input  s_ready, m_valid, m_data, core_idat, core_key, core_load, core_control
    );

endinterface

// File: rtl/present_block_ctrl.sv
// rtl/present_block_ctrl.sv - sequences 64-bit blocks through a PRESENT-80 core with ECB/CBC chaining
module present_block_ctrl
    import present_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int GUARD   = 2
) (
    input  logic                 clk,
    input  logic                 iReset_n,
    input  logic [KEY_W-1:0]     cfg_key,
    input  logic [BLOCK_W-1:0]   cfg_iv,
    input  logic                 cfg_mode,
    input  logic                 cfg_dir,
    input  logic                 cfg_init,
    present_block_ctrl_if.master bus,
    output logic                 busy,
    output logic                 err
);

    localparam logic [CNT_W-1:0] GUARD_C   = CNT_W'(GUARD);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               mode_q, dir_q;
    logic [BLOCK_W-1:0] saved_in_q, chain_q;

    logic               s_ready_q, m_valid_q, core_load_q, busy_q, err_q;
    logic [BLOCK_W-1:0] m_data_q, core_idat_q;
    logic [KEY_W-1:0]   core_key_q;
    logic               core_control_q;

    logic accept, done_ok, timed_out, capture, abort, init_ok;

    // s_ready_q is only ever set while IDLE, so it doubles as the accept qualifier
    assign accept    = (state_q == ST_IDLE) && s_ready_q && bus.s_valid;
    assign done_ok   = bus.core_done && (cnt_q >= GUARD_C);
    assign timed_out = !done_ok && (cnt_q == TIMEOUT_C);
    assign capture   = (state_q == ST_WAIT) && done_ok;
    assign abort     = (state_q == ST_WAIT) && timed_out;
    assign init_ok   = (state_q == ST_IDLE) && cfg_init && !bus.s_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (done_ok)        state_d = ST_OUT;
                else if (timed_out) state_d = ST_IDLE;
            end
            ST_OUT:  if (bus.m_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            mode_q         <= 1'b0;
            dir_q          <= 1'b0;
            saved_in_q     <= '0;
            chain_q        <= '0;
            s_ready_q      <= 1'b0;
            m_valid_q      <= 1'b0;
            core_load_q    <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            m_data_q       <= '0;
            core_idat_q    <= '0;
            core_key_q     <= '0;
            core_control_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_ready_q   <= (state_d == ST_IDLE);
            m_valid_q   <= (state_d == ST_OUT);
            core_load_q <= (state_d == ST_LOAD);
            busy_q      <= (state_d != ST_IDLE);
            cnt_q       <= (state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;

            if (accept) begin
                mode_q         <= cfg_mode;
                dir_q          <= cfg_dir;
                saved_in_q     <= bus.s_data;
                core_key_q     <= cfg_key;
                core_control_q <= cfg_dir;
                core_idat_q    <= (cfg_mode == MODE_CBC && cfg_dir == DIR_ENC) ?
                                  (bus.s_data ^ chain_q) : bus.s_data;
            end

            // m_data uses the pre-update chain; chain advances in the same cycle
            if (capture) begin
                m_data_q <= (mode_q == MODE_CBC && dir_q == DIR_DEC) ?
                            (bus.core_odat ^ chain_q) : bus.core_odat;
            end

            if (init_ok)
                chain_q <= cfg_iv;
            else if (capture && mode_q == MODE_CBC)
                chain_q <= (dir_q == DIR_DEC) ? saved_in_q : bus.core_odat;

            if (init_ok)
                err_q <= 1'b0;
            else if (abort)
                err_q <= 1'b1;
        end
    end

    assign bus.s_ready      = s_ready_q;
    assign bus.m_valid      = m_valid_q;
    assign bus.m_data       = m_data_q;
    assign bus.core_idat    = core_idat_q;
    assign bus.core_key     = core_key_q;
    assign bus.core_load    = core_load_q;
    assign bus.core_control = core_control_q;
    assign busy             = busy_q;
    assign err              = err_q;

endmodule

// File: tb/tb_present_block_ctrl.sv
// tb/tb_present_block_ctrl.sv - directed and randomized checks of present_block_ctrl against a PRESENT/ECB/CBC model
module tb_present_block_ctrl;
    import present_pkg::*;

    localparam int TIMEOUT = 1023;
    localparam int GUARD   = 2;

    logic               clk = 1'b0;
    logic               iReset_n;
    logic [KEY_W-1:0]   cfg_key;
    logic [BLOCK_W-1:0] cfg_iv;
    logic               cfg_mode, cfg_dir, cfg_init;
    logic               busy, err;

    present_block_ctrl_if bus();

    present_block_ctrl #(.TIMEOUT(TIMEOUT), .GUARD(GUARD)) dut (
        .clk      (clk),
        .iReset_n (iReset_n),
        .cfg_key  (cfg_key),
        .cfg_iv   (cfg_iv),
        .cfg_mode (cfg_mode),
        .cfg_dir  (cfg_dir),
        .cfg_init (cfg_init),
        .bus      (bus),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h21748FE3DA09B65C;
        return tbl[x*4 +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] y);
        logic [3:0] r;
        r = '0;
        for (int v = 0; v < 16; v++)
            if (sbox(4'(v)) == y) r = 4'(v);
        return r;
    endfunction

    // PRESENT-80: 31 rounds of key-add, S-layer, bit permutation, then a final key-add
    function automatic logic [63:0] present_crypt(input logic [79:0] key, input logic [63:0] din, input logic dec);
        logic [63:0] rk [1:32];
        logic [79:0] k;
        logic [63:0] s, t;
        k = key;
        for (int i = 1; i <= 32; i++) begin
            rk[i] = k[79:16];
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(i);
        end
        s = din;
        if (!dec) begin
            for (int r = 1; r <= 31; r++) begin
                s = s ^ rk[r];
                for (int j = 0; j < 16; j++) s[j*4 +: 4] = sbox(s[j*4 +: 4]);
                t = '0;
                for (int b = 0; b < 63; b++) t[(b*16) % 63] = s[b];
                t[63] = s[63];
                s = t;
            end
            s = s ^ rk[32];
        end else begin
            s = s ^ rk[32];
            for (int r = 31; r >= 1; r--) begin
                t = '0;
                for (int b = 0; b < 63; b++) t[b] = s[(b*16) % 63];
                t[63] = s[63];
                s = t;
                for (int j = 0; j < 16; j++) s[j*4 +: 4] = inv_sbox(s[j*4 +: 4]);
                s = s ^ rk[r];
            end
        end
        return s;
    endfunction

    // cipher core stand-in: result after core_lat cycles, or never when muted
    int          core_lat  = 4;
    bit          core_mute = 1'b0;
    logic        inj_done  = 1'b0;
    logic        mdl_done  = 1'b0;
    logic [63:0] mdl_odat  = '0;
    int          pend      = 0;

    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (!iReset_n) begin
            pend <= 0;
        end else if (bus.core_load) begin
            pend     <= core_lat;
            mdl_odat <= present_crypt(bus.core_key, bus.core_idat, bus.core_control);
        end else if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1 && !core_mute) mdl_done <= 1'b1;
        end
    end

    assign bus.core_done = mdl_done | inj_done;
    assign bus.core_odat = mdl_odat;

    logic [63:0] ref_chain = '0;

    task automatic ref_step(input logic mode, input logic dir, input logic [79:0] key,
                            input logic [63:0] din, output logic [63:0] dout);
        if (mode == MODE_ECB) begin
            dout = present_crypt(key, din, dir);
        end else if (dir == DIR_ENC) begin
            dout = present_crypt(key, din ^ ref_chain, 1'b0);
            ref_chain = dout;
        end else begin
            dout = present_crypt(key, din, 1'b1) ^ ref_chain;
            ref_chain = din;
        end
    endtask

    task automatic do_init(input logic [63:0] iv);
        cfg_iv   = iv;
        cfg_init = 1'b1;
        @(negedge clk);
        cfg_init  = 1'b0;
        ref_chain = iv;
        chk("init/err_clear", err, 1'b0);
    endtask

    task automatic run_block(input logic [63:0] din, input int hold, input bit inject,
                             input string tag, output logic [63:0] got);
        logic [63:0] exp, exp_idat;
        int n, loads;
        n = 0;
        while (!bus.s_ready && n < 20) begin @(negedge clk); n++; end
        chk({tag, "/s_ready_idle"}, bus.s_ready, 1'b1);
        exp_idat = (cfg_mode == MODE_CBC && cfg_dir == DIR_ENC) ? (din ^ ref_chain) : din;
        ref_step(cfg_mode, cfg_dir, cfg_key, din, exp);
        bus.s_valid = 1'b1;
        bus.s_data  = din;
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        chk({tag, "/load_n1"}, bus.core_load, 1'b1);
        chk({tag, "/s_ready_load"}, bus.s_ready, 1'b0);
        chk({tag, "/busy"}, busy, 1'b1);
        if (inject) inj_done = 1'b1;
        @(negedge clk);
        chk({tag, "/load_n2"}, bus.core_load, 1'b0);
        chk({tag, "/core_idat"}, bus.core_idat, exp_idat);
        chk({tag, "/core_key"}, bus.core_key, cfg_key);
        chk({tag, "/core_control"}, bus.core_control, cfg_dir);
        @(negedge clk);
        @(negedge clk);
        inj_done = 1'b0;
        chk({tag, "/no_early_valid"}, bus.m_valid, 1'b0);
        n = 0;
        loads = 0;
        while (!bus.m_valid && n < 2 * TIMEOUT) begin
            @(negedge clk);
            n++;
            if (bus.core_load) loads++;
        end
        chk({tag, "/m_valid"}, bus.m_valid, 1'b1);
        chk({tag, "/extra_loads"}, 80'(loads), 80'd0);
        chk({tag, "/m_data"}, bus.m_data, exp);
        got = bus.m_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"}, bus.m_valid, 1'b1);
            chk({tag, "/hold_data"}, bus.m_data, exp);
            chk({tag, "/hold_s_ready"}, bus.s_ready, 1'b0);
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        chk({tag, "/m_valid_drop"}, bus.m_valid, 1'b0);
        chk({tag, "/s_ready_after"}, bus.s_ready, 1'b1);
    endtask

    initial begin
        logic [63:0] got, c1, c2, iv;
        logic [79:0] key;
        int n, k;
        bit mv;

        iReset_n    = 1'b0;
        cfg_key     = '0;
        cfg_iv      = '0;
        cfg_mode    = MODE_ECB;
        cfg_dir     = DIR_ENC;
        cfg_init    = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst/s_ready", bus.s_ready, 1'b0);
        chk("rst/m_valid", bus.m_valid, 1'b0);
        chk("rst/core_load", bus.core_load, 1'b0);
        chk("rst/busy", busy, 1'b0);
        chk("rst/err", err, 1'b0);
        chk("rst/m_data", bus.m_data, 64'd0);
        chk("rst/core_idat", bus.core_idat, 64'd0);
        chk("rst/core_key", bus.core_key, 80'd0);
        chk("rst/core_control", bus.core_control, 1'b0);
        iReset_n = 1'b1;
        @(negedge clk);
        chk("rst/s_ready_first_edge", bus.s_ready, 1'b1);

        run_block(64'd0, 0, 1'b0, "ecb_k0", got);
        chk("ecb_k0/vector", got, 64'h5579C1387B228445);

        cfg_key = {80{1'b1}};
        run_block(64'd0, 0, 1'b0, "ecb_kf", got);
        chk("ecb_kf/vector", got, 64'hE72C46C0F5945049);
        cfg_dir = DIR_DEC;
        run_block(got, 0, 1'b0, "ecb_kf_dec", got);
        chk("ecb_kf_dec/vector", got, 64'd0);

        cfg_key  = '0;
        cfg_mode = MODE_CBC;
        cfg_dir  = DIR_ENC;
        do_init(64'd0);
        run_block(64'd0, 0, 1'b0, "cbc_e1", c1);
        chk("cbc_e1/vector", c1, 64'h5579C1387B228445);
        run_block(64'd0, 0, 1'b0, "cbc_e2", c2);
        cfg_dir = DIR_DEC;
        do_init(64'd0);
        run_block(c1, 0, 1'b0, "cbc_d1", got);
        chk("cbc_d1/vector", got, 64'd0);
        run_block(c2, 0, 1'b0, "cbc_d2", got);
        chk("cbc_d2/vector", got, 64'd0);

        for (int i = 0; i < 10; i++) begin
            cfg_mode = 1'($urandom);
            cfg_dir  = 1'($urandom);
            key      = {$urandom(), $urandom(), 16'($urandom())};
            cfg_key  = key;
            core_lat = $urandom_range(3, 12);
            if ($urandom_range(0, 2) == 0) do_init({$urandom(), $urandom()});
            run_block({$urandom(), $urandom()}, $urandom_range(0, 3), 1'b0, "rand", got);
        end

        core_lat = 5;
        run_block({$urandom(), $urandom()}, 10, 1'b0, "backpressure", got);

        core_lat = 6;
        run_block({$urandom(), $urandom()}, 0, 1'b1, "guard_inject", got);

        cfg_mode  = MODE_CBC;
        cfg_dir   = DIR_ENC;
        core_mute = 1'b1;
        n = 0;
        while (!bus.s_ready && n < 20) begin @(negedge clk); n++; end
        bus.s_valid = 1'b1;
        bus.s_data  = {$urandom(), $urandom()};
        @(negedge clk);
        bus.s_valid = 1'b0;
        chk("timeout/load", bus.core_load, 1'b1);
        k  = 0;
        mv = 1'b0;
        while (busy && k < TIMEOUT + 50) begin
            @(negedge clk);
            k++;
            if (bus.m_valid) mv = 1'b1;
        end
        chk("timeout/cycles", 80'(k), 80'(TIMEOUT + 2));
        chk("timeout/err", err, 1'b1);
        chk("timeout/no_m_valid", 80'(mv), 80'd0);
        chk("timeout/s_ready", bus.s_ready, 1'b1);
        core_mute = 1'b0;
        core_lat  = 4;
        run_block({$urandom(), $urandom()}, 0, 1'b0, "after_timeout", got);
        chk("after_timeout/err_sticky", err, 1'b1);
        iv = {$urandom(), $urandom()} | 64'h1;
        do_init(iv);

        core_lat = 12;
        n = 0;
        while (!bus.s_ready && n < 20) begin @(negedge clk); n++; end
        bus.s_valid = 1'b1;
        bus.s_data  = {$urandom(), $urandom()};
        @(negedge clk);
        bus.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst/busy_before", busy, 1'b1);
        iReset_n = 1'b0;
        #1;
        chk("midrst/s_ready", bus.s_ready, 1'b0);
        chk("midrst/m_valid", bus.m_valid, 1'b0);
        chk("midrst/core_load", bus.core_load, 1'b0);
        chk("midrst/busy", busy, 1'b0);
        chk("midrst/err", err, 1'b0);
        chk("midrst/m_data", bus.m_data, 64'd0);
        chk("midrst/core_idat", bus.core_idat, 64'd0);
        chk("midrst/core_key", bus.core_key, 80'd0);
        chk("midrst/core_control", bus.core_control, 1'b0);
        ref_chain = '0;
        @(negedge clk);
        iReset_n = 1'b1;
        core_lat = 5;
        run_block({$urandom(), $urandom()}, 0, 1'b0, "post_rst_cbc", got);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/present_block_ctrl.md
# present_block_ctrl

Block-sequencing front end for the PRESENT-80 cipher core: accepts 64-bit blocks on a valid/ready stream and issues single-cycle load commands to the core. It waits for the core's done indication and returns results on a valid/ready output stream. It supports ECB and CBC chaining in both directions and sits between the bus peripheral register file and the cipher core, acting as the initiator side of the core's load/done interface.

## Interface
- TIMEOUT, default 1023: maximum WAIT cycles before abort (10-bit counter).
- GUARD, default 2: cycles after load during which core_done is ignored.

- clk  in  1  clock
- iReset_n  in  1  reset; asynchronous assert, active-low
- cfg_key  in  80  cipher key
- cfg_iv  in  64  CBC initial vector
- cfg_mode  in  1  0=ECB, 1=CBC
- cfg_dir  in  1  0=encrypt, 1=decrypt
- cfg_init  in  1  pulse: chain<=cfg_iv, err<=0
- s_valid / s_ready  in / out  1  input block handshake
- s_data  in  64  input block
- m_valid / m_ready  out / in  1  output block handshake
- m_data  out  64  result block
- core_idat  out  64  block to core
- core_key  out  80  key to core
- core_load  out  1  one-cycle start pulse to core
- core_control  out  1  0=encrypt, 1=decrypt
- core_odat  in  64  core result
- core_done  in  1  core completion
- busy  out  1  state != IDLE
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, LOAD, WAIT, OUT.
- IDLE: s_ready=1. On s_valid, accept the block and latch key, mode, dir and s_data (saved_in). The core input is computed at accept:
  - CBC encrypt: s_data^chain
  - otherwise: s_data
- LOAD: core_load=1 for exactly one cycle, then go to WAIT.
- WAIT: the cycle counter runs from 0.
  - core_done is ignored while the counter is below GUARD.
  - First core_done at or after GUARD: capture the result and go to OUT.
    - CBC decrypt: m_data<=core_odat^chain.
    - otherwise: m_data<=core_odat.
  - Chain update at capture, CBC only: encrypt chain<=core_odat; decrypt chain<=saved_in. ECB leaves chain unchanged.
  - Counter reaching TIMEOUT without a valid done: err<=1, return to IDLE. No output, chain unchanged.
- OUT: m_valid=1 and m_data held stable until m_ready, then go to IDLE.
- cfg_init: honored only in IDLE and only when s_valid=0. It wins over block accept only in that sense; it is ignored in any other state.
- core_idat, core_key and core_control are held stable from LOAD until the block leaves WAIT.

## Timing
- Reset (async): state IDLE; s_ready, m_valid, core_load, busy and err are 0; m_data, core_idat, core_key, core_control and chain are 0. s_ready rises on the first clk edge after deassertion.
- All outputs are registered.
- Accept at cycle N: core_load high at N+1, WAIT from N+2, done sampled from N+2+GUARD.
- Done seen at cycle D: m_valid high at D+1.
- Output handshake at cycle H: s_ready high at H+1.
- Throughput: one block per core latency + 4 cycles minimum.
- Reset mid-operation: the block is abandoned, nothing is output, chain returns to 0.
- Back-to-back blocks under CBC use the chain value updated by the previous capture, never a stale value.
- core_done high in IDLE, LOAD, OUT or inside the guard window has no effect.

## Structure
- Shared package (present_pkg): state encoding, mode/dir constants, block and key widths (64/80).
- Single module, no sub-modules.
- The core is instantiated by the parent alongside this block, not inside it.

## Test plan
- ECB encrypt with key=0, s_data=0 → m_data=5579C1387B228445; core_load high exactly one cycle, at N+1.
- ECB encrypt with key=FFFF..FF (80 bits), s_data=0 → m_data=E72C46C0F5945049. Then ECB decrypt of that value with the same key → 0.
- CBC encrypt with iv=0, key=0, blocks 0 then 0:
  - block 1 → 5579C1387B228445
  - block 2 → E(5579C1387B228445)
  - CBC decrypt of both with iv=0 restores 0, 0.
- Backpressure: hold m_ready=0 for 10 cycles → m_valid and m_data stable, s_ready=0; release → s_ready=1 the next cycle.
- Done suppression and timeout:
  - Inject core_done in LOAD and in WAIT guard cycles → ignored.
  - Core model never signals done → err=1 at TIMEOUT, return to IDLE, no m_valid.
  - cfg_init in IDLE → err cleared.
- Assert iReset_n low during WAIT → all outputs 0 immediately. After release, a new block completes correctly with chain=0.
